regset_access_ctrl: RTL and testbench

- Upstream sequencer for the 8-entry negedge-clocked register set.
- Buffers host read/write commands in a small FIFO and issues each one as a single-cycle Enable/RW/Address/Data_in transaction.
- Captures read data from the register set and returns it on a valid/ready response channel.
- Runs on posedge Clk, so each register-set access is launched half a cycle before the register set samples it on negedge.

---
 rtl/regset_access_ctrl_if.sv | 20 ++
 rtl/regset_access_ctrl.sv | 106 ++++++++++
 tb/tb_regset_access_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regset_access_ctrl_if.sv
// regset_access_ctrl_if: host command/response channels plus register-set access bus
interface regset_access_ctrl_if #(parameter int N = 4);
  logic cmd_valid, cmd_ready, cmd_rw;
  logic [2:0] cmd_addr;
  logic [N-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready;
  logic [2:0] rsp_addr;
  logic [N-1:0] rsp_data;
  logic busy, rs_enable, rs_rw;
  logic [2:0] rs_address;
  logic [N-1:0] rs_data_in, rs_data_out;
  modport slave (
    input cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, rs_data_out,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, busy, rs_enable, rs_rw, rs_address, rs_data_in
  );
  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, rs_data_out,
    input cmd_ready, rsp_valid, rsp_addr, rsp_data, busy, rs_enable, rs_rw, rs_address, rs_data_in
  );
endinterface

// File: rtl/regset_access_ctrl.sv
// regset_access_ctrl: FIFO-buffered sequencer issuing single-cycle accesses to a negedge register set
module regset_access_ctrl #(
  parameter int N = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic Clk,
  input logic nReset,
  regset_access_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef struct packed {
    logic rw;
    logic [2:0] addr;
    logic [N-1:0] data;
  } cmd_t;
  state_t state_q, state_d;
  cmd_t mem_q [FIFO_DEPTH];
  cmd_t mem_d [FIFO_DEPTH];
  cmd_t head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic rs_enable_q, rs_enable_d, rs_rw_q, rs_rw_d, rsp_valid_q, rsp_valid_d;
  logic [2:0] rs_address_q, rs_address_d, rsp_addr_q, rsp_addr_d;
  logic [N-1:0] rs_data_in_q, rs_data_in_d, rsp_data_q, rsp_data_d;
  logic push, pop;
  assign bus.cmd_ready = count_q != DEPTH;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = state_q == IDLE && count_q != '0;
  assign head = mem_q[rd_ptr_q];
  assign bus.busy = state_q != IDLE || count_q != '0;
  assign bus.rs_enable = rs_enable_q;
  assign bus.rs_rw = rs_rw_q;
  assign bus.rs_address = rs_address_q;
  assign bus.rs_data_in = rs_data_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr = rsp_addr_q;
  assign bus.rsp_data = rsp_data_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    rs_enable_d = rs_enable_q;
    rs_rw_d = rs_rw_q;
    rs_address_d = rs_address_q;
    rs_data_in_d = rs_data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (pop) begin
        rs_enable_d = 1'b1;
        rs_rw_d = head.rw;
        rs_address_d = head.addr;
        rs_data_in_d = head.data;
        state_d = ISSUE;
      end
      ISSUE: begin
        rs_enable_d = 1'b0;
        state_d = rs_rw_q ? IDLE : RESP;
        if (!rs_rw_q) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d = rs_address_q;
          rsp_data_d = bus.rs_data_out;
        end
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      state_q <= IDLE;
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rs_enable_q <= 1'b0;
      rs_rw_q <= 1'b0;
      rs_address_q <= '0;
      rs_data_in_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rs_enable_q <= rs_enable_d;
      rs_rw_q <= rs_rw_d;
      rs_address_q <= rs_address_d;
      rs_data_in_q <= rs_data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
endmodule

// File: tb/tb_regset_access_ctrl.sv
// tb_regset_access_ctrl: directed checks of the sequencer against a behavioural negedge register set
module tb_regset_access_ctrl;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int pass = 0;
  int total = 0;
  logic [3:0] rmem [8];
  logic [7:0] issue_q [$];
  logic [6:0] rsp_q [$];
  logic [7:0] exp_cmd [$];
  logic [6:0] exp_rsp [$];
  logic [3:0] sweep_exp [8] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5};
  logic [6:0] bp_exp [6] = '{{3'd2, 4'd6}, {3'd0, 4'd0}, {3'd1, 4'd3}, {3'd3, 4'd9}, {3'd4, 4'd12}, {3'd5, 4'd15}};
  regset_access_ctrl_if #(.N(4)) bus();
  regset_access_ctrl #(.N(4), .FIFO_DEPTH(4)) dut (.Clk(Clk), .nReset(nReset), .bus(bus));
  always #5 Clk = ~Clk;
  always @(negedge Clk or negedge nReset)
    if (!nReset) begin
      for (int i = 0; i < 8; i++) rmem[i] <= '0;
      bus.rs_data_out <= '0;
    end else if (bus.rs_enable) begin
      if (bus.rs_rw) begin
        rmem[bus.rs_address] <= bus.rs_data_in;
        bus.rs_data_out <= 'z;
      end else bus.rs_data_out <= rmem[bus.rs_address];
    end
  always @(negedge Clk)
    if (nReset) begin
      if (bus.rs_enable) issue_q.push_back({bus.rs_rw, bus.rs_address, bus.rs_data_in});
      if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back({bus.rsp_addr, bus.rsp_data});
    end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic push(input logic rw, input logic [2:0] a, input logic [3:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = rw;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    if (n >= 200) begin
      total++;
      $display("FAIL push_timeout cmd_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL %s_idle busy=%b after %0d cycles, required 0", name, bus.busy, n);
    else pass++;
  endtask
  task automatic wait_rsp(input string name);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL %s_rsp rsp_valid=%b after %0d cycles, required 1", name, bus.rsp_valid, n);
    else pass++;
  endtask
  task automatic test_reset();
    nReset = 1'b0;
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;
    repeat (5) tick();
    total++;
    if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rs_enable} !== 4'b1000)
      $display("FAIL reset_ctrl ready/busy/rsp_valid/enable=%b required 1000", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rs_enable});
    else pass++;
    total++;
    if ({bus.rs_rw, bus.rs_address, bus.rs_data_in} !== 8'h00)
      $display("FAIL reset_rs rs_rw/addr/data=%h required 00", {bus.rs_rw, bus.rs_address, bus.rs_data_in});
    else pass++;
    total++;
    if ({bus.rsp_addr, bus.rsp_data} !== 7'h00)
      $display("FAIL reset_rsp rsp_addr/data=%h required 00", {bus.rsp_addr, bus.rsp_data});
    else pass++;
  endtask
  task automatic test_write_read();
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = 1'b1;
    bus.cmd_addr = 3'd5;
    bus.cmd_wdata = 4'hA;
    tick();
    total++;
    if (bus.rs_enable !== 1'b0) $display("FAIL wr_push_edge rs_enable=%b required 0", bus.rs_enable);
    else pass++;
    bus.cmd_rw = 1'b0;
    tick();
    total++;
    if ({bus.rs_enable, bus.rs_rw, bus.rs_address, bus.rs_data_in} !== 9'b1_1_101_1010)
      $display("FAIL wr_issue en/rw/addr/data=%b required 111011010", {bus.rs_enable, bus.rs_rw, bus.rs_address, bus.rs_data_in});
    else pass++;
    bus.cmd_valid = 1'b0;
    tick();
    total++;
    if ({bus.rs_enable, bus.rsp_valid} !== 2'b00)
      $display("FAIL wr_done en/rsp_valid=%b required 00", {bus.rs_enable, bus.rsp_valid});
    else pass++;
    tick();
    total++;
    if ({bus.rs_enable, bus.rs_rw, bus.rs_address} !== 5'b1_0_101)
      $display("FAIL rd_issue en/rw/addr=%b required 10101", {bus.rs_enable, bus.rs_rw, bus.rs_address});
    else pass++;
    tick();
    total++;
    if ({bus.rs_enable, bus.rsp_valid, bus.rsp_addr, bus.rsp_data} !== {1'b0, 1'b1, 3'd5, 4'hA})
      $display("FAIL rd_rsp en/valid/addr/data=%b required 011011010", {bus.rs_enable, bus.rsp_valid, bus.rsp_addr, bus.rsp_data});
    else pass++;
    tick();
    total++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL rd_ack valid/busy=%b required 00", {bus.rsp_valid, bus.busy});
    else pass++;
  endtask
  task automatic test_sweep();
    rsp_q.delete();
    issue_q.delete();
    bus.rsp_ready = 1'b1;
    for (int a = 0; a < 8; a++) push(1'b1, 3'(a), 4'((3 * a) % 16));
    for (int a = 0; a < 8; a++) push(1'b0, 3'(a), 4'h0);
    wait_idle("sweep");
    total++;
    if (rsp_q.size() != 8) $display("FAIL sweep_rsp_count got %0d required 8", rsp_q.size());
    else pass++;
    total++;
    if (issue_q.size() != 16) $display("FAIL sweep_issue_count got %0d required 16", issue_q.size());
    else pass++;
    for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
      total++;
      if (rsp_q[i] !== {3'(i), sweep_exp[i]}) $display("FAIL sweep_rsp%0d got %h required %h", i, rsp_q[i], {3'(i), sweep_exp[i]});
      else pass++;
    end
  endtask
  task automatic test_back_pressure();
    bus.rsp_ready = 1'b0;
    rsp_q.delete();
    push(1'b0, 3'd2, 4'h0);
    wait_rsp("bp");
    total++;
    if ({bus.rsp_addr, bus.rsp_data} !== {3'd2, 4'd6}) $display("FAIL bp_first got %h required %h", {bus.rsp_addr, bus.rsp_data}, {3'd2, 4'd6});
    else pass++;
    push(1'b0, 3'd0, 4'h0);
    push(1'b0, 3'd1, 4'h0);
    push(1'b0, 3'd3, 4'h0);
    push(1'b0, 3'd4, 4'h0);
    total++;
    if (bus.cmd_ready !== 1'b0) $display("FAIL bp_full cmd_ready=%b required 0", bus.cmd_ready);
    else pass++;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = 3'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus.cmd_ready, bus.rs_enable, bus.rsp_valid, bus.rsp_addr, bus.rsp_data} !== {1'b0, 1'b0, 1'b1, 3'd2, 4'd6})
        $display("FAIL bp_stall%0d ready/en/valid/addr/data=%b required 0010100110", i, {bus.cmd_ready, bus.rs_enable, bus.rsp_valid, bus.rsp_addr, bus.rsp_data});
      else pass++;
    end
    bus.rsp_ready = 1'b1;
    push(1'b0, 3'd5, 4'h0);
    wait_idle("bp");
    total++;
    if (rsp_q.size() != 6) $display("FAIL bp_rsp_count got %0d required 6", rsp_q.size());
    else pass++;
    for (int i = 0; i < 6 && i < rsp_q.size(); i++) begin
      total++;
      if (rsp_q[i] !== bp_exp[i]) $display("FAIL bp_rsp%0d got %h required %h", i, rsp_q[i], bp_exp[i]);
      else pass++;
    end
  endtask
  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    push(1'b0, 3'd1, 4'h0);
    wait_rsp("rm");
    repeat (4) push(1'b1, 3'd7, 4'hF);
    total++;
    if (bus.cmd_ready !== 1'b0) $display("FAIL rm_full cmd_ready=%b required 0", bus.cmd_ready);
    else pass++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    total++;
    if ({bus.rs_enable, bus.rs_rw, bus.rs_address} !== 5'b11111)
      $display("FAIL rm_issue en/rw/addr=%b required 11111", {bus.rs_enable, bus.rs_rw, bus.rs_address});
    else pass++;
    #1 nReset = 1'b0;
    #1;
    total++;
    if ({bus.rs_enable, bus.busy, bus.rsp_valid, bus.cmd_ready} !== 4'b0001)
      $display("FAIL rm_async en/busy/valid/ready=%b required 0001", {bus.rs_enable, bus.busy, bus.rsp_valid, bus.cmd_ready});
    else pass++;
    #4 nReset = 1'b1;
    issue_q.delete();
    rsp_q.delete();
    repeat (5) tick();
    total++;
    if (issue_q.size() != 0 || bus.busy !== 1'b0) $display("FAIL rm_stale issues=%0d busy=%b required 0 and 0", issue_q.size(), bus.busy);
    else pass++;
    bus.rsp_ready = 1'b1;
    push(1'b0, 3'd7, 4'h0);
    wait_idle("rm");
    total++;
    if (rsp_q.size() != 1 || rsp_q[0] !== {3'd7, 4'd0}) $display("FAIL rm_fresh count=%0d first=%h required 1 and 70", rsp_q.size(), rsp_q.size() ? rsp_q[0] : 7'h0);
    else pass++;
  endtask
  task automatic test_random();
    logic [3:0] shadow [8];
    int occ;
    logic pushed;
    logic [7:0] mask;
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    issue_q.delete();
    rsp_q.delete();
    exp_cmd.delete();
    exp_rsp.delete();
    bus.rsp_ready = 1'b0;
    push(1'b0, 3'd3, 4'h0);
    exp_cmd.push_back({1'b0, 3'd3, 4'h0});
    wait_rsp("rnd");
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 3'(2 * i + 1), 4'(5 + i));
      exp_cmd.push_back({1'b1, 3'(2 * i + 1), 4'(5 + i)});
    end
    occ = 3;
    for (int c = 0; c < 20; c++) begin
      bus.cmd_valid = 1'($urandom);
      bus.cmd_rw = 1'($urandom);
      bus.cmd_addr = 3'($urandom);
      bus.cmd_wdata = 4'($urandom);
      bus.rsp_ready = 1'($urandom);
      total++;
      if (bus.cmd_ready !== (occ < 4)) $display("FAIL rnd_ready%0d cmd_ready=%b required %b (occupancy %0d)", c, bus.cmd_ready, occ < 4, occ);
      else pass++;
      pushed = bus.cmd_valid && bus.cmd_ready;
      if (pushed) exp_cmd.push_back({bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata});
      tick();
      occ = occ + int'(pushed) - int'(bus.rs_enable);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle("rnd");
    total++;
    if (issue_q.size() != exp_cmd.size()) $display("FAIL rnd_issue_count got %0d required %0d", issue_q.size(), exp_cmd.size());
    else pass++;
    for (int i = 0; i < exp_cmd.size() && i < issue_q.size(); i++) begin
      mask = exp_cmd[i][7] ? 8'hFF : 8'hF0;
      total++;
      if ((issue_q[i] & mask) !== (exp_cmd[i] & mask)) $display("FAIL rnd_issue%0d got %h required %h", i, issue_q[i] & mask, exp_cmd[i] & mask);
      else pass++;
    end
    for (int i = 0; i < exp_cmd.size(); i++)
      if (exp_cmd[i][7]) shadow[exp_cmd[i][6:4]] = exp_cmd[i][3:0];
      else exp_rsp.push_back({exp_cmd[i][6:4], shadow[exp_cmd[i][6:4]]});
    total++;
    if (rsp_q.size() != exp_rsp.size()) $display("FAIL rnd_rsp_count got %0d required %0d", rsp_q.size(), exp_rsp.size());
    else pass++;
    for (int i = 0; i < exp_rsp.size() && i < rsp_q.size(); i++) begin
      total++;
      if (rsp_q[i] !== exp_rsp[i]) $display("FAIL rnd_rsp%0d got %h required %h", i, rsp_q[i], exp_rsp[i]);
      else pass++;
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_sweep();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
